// File: rtl/im_port_arbiter_if.sv
// Bundle between im_port_arbiter and its environment: loader stream, F-stage
// fetch, IM array port and status. master = arbiter side, slave = environment.
interface im_port_arbiter_if #(
  parameter int AW = 12
);
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          reload_req;
  logic [31:0]   f_pc;
  logic          f_gnt;
  logic [31:0]   f_instr;
  logic          f_fault;
  logic [AW-1:0] im_addr;
  logic          im_we;
  logic [31:0]   im_wdata;
  logic [31:0]   im_rdata;
  logic          run;
  logic [AW:0]   ld_count;
  logic          ld_ovf;
  logic [31:0]   ld_sum;

  modport master (
    input  ld_valid, ld_data, ld_last, reload_req, f_pc, im_rdata,
    output ld_ready, f_gnt, f_instr, f_fault, im_addr, im_we, im_wdata,
           run, ld_count, ld_ovf, ld_sum
  );

  modport slave (
    output ld_valid, ld_data, ld_last, reload_req, f_pc, im_rdata,
    input  ld_ready, f_gnt, f_instr, f_fault, im_addr, im_we, im_wdata,
           run, ld_count, ld_ovf, ld_sum
  );
endinterface

// File: rtl/im_port_arbiter.sv
// Shares the single IM port between the image loader and F-stage fetch, sequencing
// IDLE -> LOAD -> RUN (-> FLUSH -> LOAD). Optional feature macro: IM_LOAD_CHECKSUM_EN.
module im_port_arbiter #(
  parameter int          IM_DEPTH  = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h3000
) (
  input  logic                clk,
  input  logic                reset_n,
  im_port_arbiter_if.master   bus
);
  localparam int AW = $clog2(IM_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Fetch window bounds held in 33 bits so the upper bound cannot wrap.
  localparam logic [32:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI   = {1'b0, BASE_ADDR} + (33'(IM_DEPTH) << 2);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(IM_DEPTH - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [AW:0] r_count;
  logic        r_ovf;
  logic        w_hs;
  logic        w_at_end;
  logic        w_entry;
  logic        w_fault;
  logic [32:0] w_pc33;
  logic [31:0] w_off;

  assign w_hs     = (r_state == S_LOAD) && bus.ld_valid;
  assign w_at_end = (r_count == LAST_IDX);
  assign w_entry  = (r_state == S_IDLE) || (r_state == S_FLUSH);
  assign w_pc33   = {1'b0, bus.f_pc};
  assign w_off    = bus.f_pc - BASE_ADDR;
  assign w_fault  = (bus.f_pc[1:0] != 2'b00) || (w_pc33 < WIN_LO) || (w_pc33 >= WIN_HI);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_LOAD;
      S_LOAD: begin
        if (w_hs && (bus.ld_last || w_at_end)) begin
          w_next = S_RUN;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_RUN: begin
        if (bus.reload_req) begin
          w_next = S_FLUSH;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FLUSH: w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Write pointer doubles as the word count; it stops at IM_DEPTH because LOAD exits there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_entry) begin
        r_count <= '0;
      end else if (w_hs) begin
        r_count <= r_count + (AW+1)'(1);
      end
      if (w_hs && w_at_end && !bus.ld_last) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef IM_LOAD_CHECKSUM_EN
  logic [31:0] r_sum;

  // Running mod-2^32 sum of accepted loader words
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= 32'h0;
    end else if (w_entry) begin
      r_sum <= 32'h0;
    end else if (w_hs) begin
      r_sum <= r_sum + bus.ld_data;
    end
  end

  assign bus.ld_sum = r_sum;
`else
  assign bus.ld_sum = 32'h0;
`endif

  // Port mux: the loader owns the IM in LOAD, the fetch path in RUN, nobody otherwise
  always_comb begin
    bus.ld_ready = 1'b0;
    bus.f_gnt    = 1'b0;
    bus.f_instr  = 32'h0;
    bus.f_fault  = 1'b0;
    bus.im_addr  = '0;
    bus.im_we    = 1'b0;
    bus.im_wdata = 32'h0;
    case (r_state)
      S_LOAD: begin
        bus.ld_ready = 1'b1;
        bus.im_addr  = r_count[AW-1:0];
        bus.im_we    = w_hs;
        if (w_hs) begin
          bus.im_wdata = bus.ld_data;
        end else begin
          bus.im_wdata = 32'h0;
        end
      end
      S_RUN: begin
        bus.f_gnt   = 1'b1;
        bus.im_addr = AW'(w_off >> 2);
        bus.f_fault = w_fault;
        if (w_fault) begin
          bus.f_instr = 32'h0;
        end else begin
          bus.f_instr = bus.im_rdata;
        end
      end
      default: begin
        bus.ld_ready = 1'b0;
      end
    endcase
  end

  assign bus.run      = (r_state == S_RUN);
  assign bus.ld_count = r_count;
  assign bus.ld_ovf   = r_ovf;
endmodule
